// File: rtl/fir_mb_tdm_if.sv
// Sample / coefficient / result bundle of the multi-band TDM FIR.
// The master side is the sample source and coefficient loader, the slave side is the filter.
interface fir_mb_tdm_if #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 30,
  parameter int NBANDS = 4
);
  localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int ADDR_W = $clog2(TAPS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] fir_in;
  logic [BAND_W-1:0] band_sel;
  logic              coef_we;
  logic              coef_ready;
  logic [BAND_W-1:0] coef_band;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              out_valid;
  logic [DATA_W-1:0] fir_out;
  logic              sat_flag;

  modport master (
    output in_valid, fir_in, band_sel, coef_we, coef_band, coef_addr, coef_data,
    input  in_ready, coef_ready, out_valid, fir_out, sat_flag
  );

  modport slave (
    input  in_valid, fir_in, band_sel, coef_we, coef_band, coef_addr, coef_data,
    output in_ready, coef_ready, out_valid, fir_out, sat_flag
  );
endinterface

// File: rtl/fir_mb_tdm.sv
// Time-multiplexed multi-band FIR: one shared MAC walks TAPS taps per accepted sample,
// using the coefficient set of the band latched with that sample. Sign-magnitude I/O.
module fir_mb_tdm #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15,
  parameter int TAPS   = 30,
  parameter int NBANDS = 4
) (
  input  logic        clk_slow,
  input  logic        rst,
  fir_mb_tdm_if.slave bus
);
  localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = 2 * DATA_W - 1;
  localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS);
  localparam logic [DATA_W-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   state_q;
  logic [DATA_W-1:0]        coef_q [NBANDS][TAPS];
  logic [DATA_W-1:0]        hist_q [TAPS];
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         k_q;
  logic [BAND_W-1:0]        band_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        fir_out_q;
  logic                     out_valid_q;
  logic                     sat_q;

  logic [PTR_W-1:0]         rd_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]         abs_acc;
  logic [ACC_W-1:0]         shifted;
  logic                     sat_d;
  logic [DATA_W-2:0]        mag_d;
  logic [DATA_W-1:0]        fir_out_d;

  // Sign-magnitude to two's complement; negative zero naturally maps to 0.
  function automatic logic signed [PROD_W-1:0] sm2s(input logic [DATA_W-1:0] v);
    logic signed [PROD_W-1:0] m;
    m = {{(PROD_W - DATA_W + 1){1'b0}}, v[DATA_W-2:0]};
    return v[DATA_W-1] ? -m : m;
  endfunction

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.coef_ready = (state_q == S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.fir_out    = fir_out_q;
  assign bus.sat_flag   = sat_q;

  // MAC datapath and output formatting of the running sum including the current tap.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    rd_idx    = (ptr_q >= k_q) ? (ptr_q - k_q) : (ptr_q + PTR_W'(TAPS) - k_q);
    prod      = sm2s(coef_q[band_q][k_q]) * sm2s(hist_q[rd_idx]);
    acc_d     = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    abs_acc   = acc_d[ACC_W-1] ? -acc_d : acc_d;
    shifted   = abs_acc >> FRAC_W;
    sat_d     = (shifted > {{(ACC_W - DATA_W + 1){1'b0}}, MAG_MAX});
    mag_d     = sat_d ? MAG_MAX : shifted[DATA_W-2:0];
    fir_out_d = {acc_d[ACC_W-1] && (mag_d != '0), mag_d};
  end

  // Coefficient bank: writes land only while idle and only for in-range band/tap.
  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      // NOTE: the arrays are reset on purpose: a reset must flush every coefficient and
      // history sample, which also keeps them out of reset-less RAM macros.
      for (int b = 0; b < NBANDS; b++)
        for (int t = 0; t < TAPS; t++)
          coef_q[b][t] <= '0;
    end else if (bus.coef_we && state_q == S_IDLE &&
                 int'(bus.coef_band) < NBANDS && int'(bus.coef_addr) < TAPS) begin
      coef_q[bus.coef_band][bus.coef_addr] <= bus.coef_data;
    end
  end

  // Control FSM: accept a sample, run TAPS MAC cycles, present the result for one cycle.
  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      k_q         <= '0;
      band_q      <= '0;
      acc_q       <= '0;
      fir_out_q   <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      for (int t = 0; t < TAPS; t++)
        hist_q[t] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            hist_q[ptr_q] <= bus.fir_in;
            band_q        <= (int'(bus.band_sel) < NBANDS) ? bus.band_sel : '0;
            acc_q         <= '0;
            k_q           <= '0;
            state_q       <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == PTR_W'(TAPS - 1)) begin
            // Result registered on the last MAC edge so out_valid is high during OUT.
            fir_out_q   <= fir_out_d;
            out_valid_q <= 1'b1;
            sat_q       <= sat_q | sat_d;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          ptr_q   <= (ptr_q == PTR_W'(TAPS - 1)) ? '0 : ptr_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mb_tdm.sv
// Self-checking bench for fir_mb_tdm: directed scenarios plus random traffic checked
// against a queue-based convolution model of the filter.
module tb_fir_mb_tdm;
  localparam int DW = 16;
  localparam int TAPS = 30;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mb_tdm_if #(.DATA_W(DW), .TAPS(TAPS), .NBANDS(NB)) bus ();

  fir_mb_tdm #(.DATA_W(DW), .FRAC_W(15), .TAPS(TAPS), .NBANDS(NB)) dut (
    .clk_slow (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: real-valued taps (scaled integers), newest sample at the queue front.
  int c_m [NB][TAPS];
  int hist_m [$];
  bit sat_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sm2i(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic [15:0] model_out(input int band);
    longint s = 0;
    longint mag;
    for (int k = 0; k < TAPS; k++) s += longint'(c_m[band][k]) * longint'(hist_m[k]);
    mag = (s < 0 ? -s : s) / 32768;
    if (mag > 32767) begin
      mag = 32767;
      sat_m = 1'b1;
    end
    return {(s < 0 && mag != 0), mag[14:0]};
  endfunction

  task automatic model_reset();
    foreach (c_m[b, t]) c_m[b][t] = 0;
    hist_m = {};
    repeat (TAPS) hist_m.push_back(0);
    sat_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic write_coef(input int band, input int addr, input logic [15:0] data);
    wait_ready();
    bus.coef_we = 1'b1;
    bus.coef_band = 2'(band);
    bus.coef_addr = 5'(addr);
    bus.coef_data = data;
    @(posedge clk);
    if (addr < TAPS && band < NB) c_m[band][addr] = sm2i(data);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  // Accepts one sample (optionally with a coefficient write in the same cycle) and checks
  // latency, value, sticky flag and the single-cycle pulse against the model.
  task automatic send_sample(input logic [15:0] data, input int band, input bit with_we,
                             input int wb, input int wa, input logic [15:0] wd,
                             output logic [15:0] got);
    int lat;
    logic [15:0] exp;
    wait_ready();
    bus.fir_in = data;
    bus.band_sel = 2'(band);
    bus.in_valid = 1'b1;
    if (with_we) begin
      bus.coef_we = 1'b1;
      bus.coef_band = 2'(wb);
      bus.coef_addr = 5'(wa);
      bus.coef_data = wd;
    end
    @(posedge clk);
    if (with_we && wa < TAPS && wb < NB) c_m[wb][wa] = sm2i(wd);
    hist_m.push_front(sm2i(data));
    void'(hist_m.pop_back());
    exp = model_out(band);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    bus.band_sel = 2'($urandom_range(0, 3));
    bus.fir_in = 16'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < TAPS + 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    // Accepting cycle plus TAPS MAC cycles: out_valid is seen after the TAPS-th edge.
    check("latency", 32'(lat), 32'(TAPS));
    check("fir_out", 32'(bus.fir_out), 32'(exp));
    check("sat_flag", 32'(bus.sat_flag), 32'(sat_m));
    got = bus.fir_out;
    @(posedge clk);
    @(negedge clk);
    check("pulse_one_cycle", 32'(bus.out_valid), 32'd0);
    check("ready_after_out", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int acc_t [$];
    bit we_done;

    bus.in_valid = 1'b0;
    bus.fir_in = '0;
    bus.band_sel = '0;
    bus.coef_we = 1'b0;
    bus.coef_band = '0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    model_reset();

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fir_out", 32'(bus.fir_out), 32'd0);
    check("rst_sat", 32'(bus.sat_flag), 32'd0);
    do_reset();
    check("coef_ready_idle", 32'(bus.coef_ready), 32'd1);

    // Impulse response on band 0
    write_coef(0, 0, 16'h4000);
    write_coef(0, 1, 16'hC000);
    send_sample(16'h4000, 0, 0, 0, 0, '0, got);
    check("imp_0", 32'(got), 32'h2000);
    send_sample(16'h0000, 0, 0, 0, 0, '0, got);
    check("imp_1", 32'(got), 32'hA000);
    send_sample(16'h0000, 0, 0, 0, 0, '0, got);
    check("imp_2", 32'(got), 32'h0000);
    send_sample(16'h0000, 0, 0, 0, 0, '0, got);

    // Band switching on constant input, shared history
    for (int i = 0; i < 6; i++) begin
      send_sample(16'h4000, i % 2, 0, 0, 0, '0, got);
      if (i % 2 == 1) check("band1_zero", 32'(got), 32'h0000);
    end

    // Negative zero and sign handling
    do_reset();
    write_coef(0, 0, 16'h4000);
    send_sample(16'h8000, 0, 0, 0, 0, '0, got);
    check("neg_zero_in", 32'(got), 32'h0000);
    send_sample(16'h8001, 0, 0, 0, 0, '0, got);
    check("neg_trunc_zero", 32'(got), 32'h0000);
    send_sample(16'hC000, 0, 0, 0, 0, '0, got);
    check("neg_quarter", 32'(got), 32'hA000);

    // Handshake: in_valid held high, coefficient write attempted during MAC
    do_reset();
    write_coef(0, 0, 16'h4000);
    we_done = 1'b0;
    bus.fir_in = 16'h0000;
    bus.band_sel = 2'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3 * (TAPS + 2) + 1; i++) begin
      if (bus.in_ready === 1'b1) begin
        acc_t.push_back(i);
        hist_m.push_front(0);
        void'(hist_m.pop_back());
      end
      if (!we_done && acc_t.size() == 1 && i == acc_t[0] + 5) begin
        check("we_during_mac", 32'(bus.coef_ready), 32'd0);
        bus.coef_we = 1'b1;
        bus.coef_band = 2'd0;
        bus.coef_addr = 5'd0;
        bus.coef_data = 16'h7FFF;
        we_done = 1'b1;
      end else begin
        bus.coef_we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    check("hs_accept_count", 32'(acc_t.size()), 32'd4);
    for (int j = 1; j < acc_t.size(); j++)
      check("hs_spacing", 32'(acc_t[j] - acc_t[j-1]), 32'(TAPS + 2));
    send_sample(16'h4000, 0, 0, 0, 0, '0, got);
    check("dropped_write", 32'(got), 32'h2000);

    // Same-cycle coefficient write and sample acceptance
    send_sample(16'h4000, 0, 1, 0, 0, 16'h2000, got);

    // Saturation with sticky flag
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(0, k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) send_sample(16'h7FFF, 0, 0, 0, 0, '0, got);
    check("sat_pos", 32'(got), 32'h7FFF);
    for (int i = 0; i < TAPS; i++) send_sample(16'hFFFF, 0, 0, 0, 0, '0, got);
    check("sat_neg", 32'(got), 32'hFFFF);
    check("sat_sticky", 32'(bus.sat_flag), 32'd1);

    // Reset at MAC cycle 10
    wait_ready();
    bus.fir_in = 16'h4000;
    bus.band_sel = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_fir_out", 32'(bus.fir_out), 32'd0);
    check("midrst_sat", 32'(bus.sat_flag), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_sample(16'h4000, 0, 0, 0, 0, '0, got);
    check("post_rst_impulse", 32'(got), 32'h0000);

    // Random traffic, including out-of-range tap writes
    do_reset();
    for (int i = 0; i < 24; i++)
      write_coef($urandom_range(0, NB - 1), $urandom_range(0, 31),
                 {1'($urandom), 2'b00, 13'($urandom)});
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        send_sample(16'($urandom), $urandom_range(0, NB - 1), 1, $urandom_range(0, NB - 1),
                    $urandom_range(0, 31), {1'($urandom), 1'b0, 14'($urandom)}, got);
      else
        send_sample(16'($urandom), $urandom_range(0, NB - 1), 0, 0, 0, '0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
